sdram_wire_responder: RTL and testbench

Synthesizable SDR-SDRAM device-side responder for the 16-bit `sdram_wire_*` bus driven by the multicore system's SDRAM controller. It decodes the controller's commands, tracks per-bank open rows, stores write data in an internal array, and returns read data at the programmed CAS latency. It flags protocol violations, so it serves both as an on-FPGA loopback target and as the checking end of the controller in simulation.

---
 rtl/sdram_resp_pkg.sv | 43 ++++
 rtl/sdram_resp_read_pipe.sv | 48 ++++
 rtl/sdram_wire_responder.sv | 170 +++++++++++++++++
 tb/tb_sdram_wire_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_resp_pkg.sv
// Shared encodings for the SDR-SDRAM device-side responder: bus commands,
// init sequencing states and violation codes.
package sdram_resp_pkg;

  typedef enum logic [3:0] {
    CMD_LMR   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_BST   = 4'b0110,
    CMD_NOP   = 4'b0111,
    CMD_DESEL = 4'b1111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_INIT_PRE,
    ST_INIT_REF,
    ST_INIT_LMR,
    ST_READY
  } init_state_e;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_NOT_INIT    = 3'd1,
    ERR_BAD_MODE    = 3'd2,
    ERR_BANK_OPEN   = 3'd3,
    ERR_BANK_CLOSED = 3'd4,
    ERR_REF_OPEN    = 3'd5,
    ERR_CONTENTION  = 3'd6
  } err_e;

  localparam logic [2:0] CL_DEFAULT = 3'd3;

  // A deselected chip ignores ras/cas/we, so all cs_n=1 patterns collapse to one code.
  function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    if (cs_n) return CMD_DESEL;
    return cmd_e'({1'b0, ras_n, cas_n, we_n});
  endfunction

endpackage

// File: rtl/sdram_resp_read_pipe.sv
// Read-data delay line: a READ enters stage 0 and leaves the tap selected by
// the CAS latency; the whole line freezes while cke is low.
module sdram_resp_read_pipe #(
  parameter int DQ_W  = 16,
  parameter int LANES = DQ_W / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cke_i,
  input  logic             push_i,
  input  logic [DQ_W-1:0]  data_i,
  input  logic [LANES-1:0] dqm_i,
  input  logic             cl3_i,
  output logic [LANES-1:0] lane_oe_o,
  output logic [DQ_W-1:0]  data_o
);

  localparam int DEPTH = 3;

  logic [DEPTH-1:0] valid_q;
  logic [DQ_W-1:0]  data_q [DEPTH];
  logic [LANES-1:0] dqm_q  [DEPTH];
  logic [1:0]       tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        dqm_q[i]  <= '1;
      end
    end else if (cke_i) begin
      valid_q   <= {valid_q[DEPTH-2:0], push_i};
      data_q[0] <= data_i;
      dqm_q[0]  <= dqm_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        dqm_q[i]  <= dqm_q[i-1];
      end
    end
  end

  // Stage k holds a READ issued k+1 edges ago, so CL=n taps stage n-1.
  assign tap       = cl3_i ? 2'd2 : 2'd1;
  assign lane_oe_o = valid_q[tap] ? ~dqm_q[tap] : '0;
  assign data_o    = data_q[tap];

endmodule

// File: rtl/sdram_wire_responder.sv
// SDR-SDRAM device model: decodes controller commands, tracks open rows per
// bank, stores write data and returns reads at the programmed CAS latency.
module sdram_wire_responder
  import sdram_resp_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int COL_W       = 9,
  parameter int ROW_STORE_W = 3,
  parameter int DQ_W        = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   sdram_wire_addr,
  input  logic [1:0]          sdram_wire_ba,
  input  logic                sdram_wire_cs_n,
  input  logic                sdram_wire_ras_n,
  input  logic                sdram_wire_cas_n,
  input  logic                sdram_wire_we_n,
  input  logic                sdram_wire_cke,
  input  logic [DQ_W/8-1:0]   sdram_wire_dqm,
  inout  wire  [DQ_W-1:0]     sdram_wire_dq,
  output logic                init_done,
  output logic                err_pulse,
  output logic [2:0]          err_code
);

  localparam int LANES = DQ_W / 8;
  localparam int IDX_W = 2 + ROW_STORE_W + COL_W;
  localparam int WORDS = 1 << IDX_W;

  init_state_e            state_q, state_d;
  logic                   ref_cnt_q, ref_cnt_d;
  logic [2:0]             cl_q, cl_d;
  logic [3:0]             open_q, open_d;
  logic [ROW_STORE_W-1:0] row_q [4];
  logic [ROW_STORE_W-1:0] row_d [4];
  logic                   err_pulse_q;
  err_e                   err_code_q, err;

  cmd_e                   cmd;
  logic                   a10, cmd_idle, mode_ok, do_lmr, wr_en, rd_push, dq_busy;
  logic [IDX_W-1:0]       acc_idx;
  logic [DQ_W-1:0]        mem [WORDS];
  logic [LANES-1:0]       dq_lane_oe;
  logic [DQ_W-1:0]        rd_dq;
  logic                   unused_addr;

  assign cmd         = decode_cmd(sdram_wire_cs_n, sdram_wire_ras_n, sdram_wire_cas_n, sdram_wire_we_n);
  assign a10         = sdram_wire_addr[10];
  assign cmd_idle    = (cmd == CMD_DESEL) || (cmd == CMD_NOP) || (cmd == CMD_BST);
  assign mode_ok     = (sdram_wire_addr[2:0] == 3'b000) &&
                       ((sdram_wire_addr[6:4] == 3'd2) || (sdram_wire_addr[6:4] == 3'd3));
  assign acc_idx     = {sdram_wire_ba, row_q[sdram_wire_ba], sdram_wire_addr[COL_W-1:0]};
  assign dq_busy     = |dq_lane_oe;
  assign unused_addr = ^{sdram_wire_addr[ADDR_W-1:11], sdram_wire_addr[9]};

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    cl_d      = cl_q;
    open_d    = open_q;
    row_d     = row_q;
    err       = ERR_NONE;
    do_lmr    = 1'b0;
    wr_en     = 1'b0;
    rd_push   = 1'b0;
    if (sdram_wire_cke) begin
      if (state_q != ST_READY) begin
        case (state_q)
          ST_INIT_PRE:
            if (cmd == CMD_PRE && a10) begin
              state_d   = ST_INIT_REF;
              ref_cnt_d = 1'b0;
            end else if (!cmd_idle) err = ERR_NOT_INIT;
          ST_INIT_REF:
            if (cmd == CMD_REF) begin
              ref_cnt_d = 1'b1;
              if (ref_cnt_q) state_d = ST_INIT_LMR;
            end else if (!cmd_idle) err = ERR_NOT_INIT;
          ST_INIT_LMR:
            if (cmd == CMD_LMR) begin
              do_lmr  = 1'b1;
              state_d = ST_READY;
            end else if (!cmd_idle) err = ERR_NOT_INIT;
          default: ;
        endcase
      end else begin
        case (cmd)
          CMD_ACT: begin
            if (open_q[sdram_wire_ba]) err = ERR_BANK_OPEN;
            open_d[sdram_wire_ba] = 1'b1;
            row_d[sdram_wire_ba]  = sdram_wire_addr[ROW_STORE_W-1:0];
          end
          CMD_READ, CMD_WRITE: begin
            if (!open_q[sdram_wire_ba]) err = ERR_BANK_CLOSED;
            else begin
              if (cmd == CMD_WRITE) begin
                wr_en = 1'b1;
                if (dq_busy) err = ERR_CONTENTION;
              end else rd_push = 1'b1;
              if (a10) open_d[sdram_wire_ba] = 1'b0;
            end
          end
          CMD_PRE:
            if (a10) open_d = '0;
            else     open_d[sdram_wire_ba] = 1'b0;
          CMD_REF: if (|open_q) err = ERR_REF_OPEN;
          CMD_LMR: do_lmr = 1'b1;
          default: ;
        endcase
      end
      if (do_lmr) begin
        if (|open_q)       err  = ERR_BANK_OPEN;
        else if (!mode_ok) err  = ERR_BAD_MODE;
        else               cl_d = sdram_wire_addr[6:4];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; the comb block above uses blocking ones.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_INIT_PRE;
      ref_cnt_q   <= 1'b0;
      cl_q        <= CL_DEFAULT;
      open_q      <= '0;
      for (int b = 0; b < 4; b++) row_q[b] <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      ref_cnt_q   <= ref_cnt_d;
      cl_q        <= cl_d;
      open_q      <= open_d;
      row_q       <= row_d;
      err_pulse_q <= (err != ERR_NONE);
      if (err != ERR_NONE) err_code_q <= err;
    end
  end

  // NOTE: storage has no reset so it maps to block RAM and survives a controller reset.
  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++)
        if (!sdram_wire_dqm[l]) mem[acc_idx][l*8 +: 8] <= sdram_wire_dq[l*8 +: 8];
    end
  end

  sdram_resp_read_pipe #(.DQ_W(DQ_W), .LANES(LANES)) u_read_pipe (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .cke_i     (sdram_wire_cke),
    .push_i    (rd_push),
    .data_i    (mem[acc_idx]),
    .dqm_i     (sdram_wire_dqm),
    .cl3_i     (cl_q == 3'd3),
    .lane_oe_o (dq_lane_oe),
    .data_o    (rd_dq)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_dq_lane
    assign sdram_wire_dq[l*8 +: 8] = dq_lane_oe[l] ? rd_dq[l*8 +: 8] : 8'hzz;
  end

  assign init_done = (state_q == ST_READY);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_sdram_wire_responder.sv
// Scoreboard bench for sdram_wire_responder: a small bank/row/storage model
// queues expected read beats and error pulses, checked every falling edge.
module tb_sdram_wire_responder;
  import sdram_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] addr;
  logic [1:0]  ba, dqm;
  logic        cs_n, ras_n, cas_n, we_n, cke;
  logic        tb_drive;
  logic [15:0] tb_dq;
  wire  [15:0] dq;
  logic        init_done, err_pulse;
  logic [2:0]  err_code;

  always #5 clk = ~clk;
  assign dq = tb_drive ? tb_dq : 16'hzzzz;

  sdram_wire_responder dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .sdram_wire_addr (addr),
    .sdram_wire_ba   (ba),
    .sdram_wire_cs_n (cs_n),
    .sdram_wire_ras_n(ras_n),
    .sdram_wire_cas_n(cas_n),
    .sdram_wire_we_n (we_n),
    .sdram_wire_cke  (cke),
    .sdram_wire_dqm  (dqm),
    .sdram_wire_dq   (dq),
    .init_done       (init_done),
    .err_pulse       (err_pulse),
    .err_code        (err_code)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [1:0]  oe;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  rd_exp_t     popped;
  bit          popped_v;
  int          edge_cnt = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] mem_m [int];
  logic [2:0]  row_m [4];
  int          cl_m;
  logic [2:0]  pend_err, code_m;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [15:0] m;
    popped_v = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
      popped   = exp_q.pop_front();
      popped_v = 1'b1;
      check("rd_oe", {30'd0, dut.dq_lane_oe}, {30'd0, popped.oe});
      m = {{8{popped.oe[1]}}, {8{popped.oe[0]}}};
      if (m != 16'h0) check("rd_data", {16'd0, dq & m}, {16'd0, popped.data & m});
    end else begin
      check("idle_oe", {30'd0, dut.dq_lane_oe}, 32'd0);
    end
    check("err_pulse", {31'd0, err_pulse}, {31'd0, pend_err != 3'd0});
    if (pend_err != 3'd0) code_m = pend_err;
    check("err_code", {29'd0, err_code}, {29'd0, code_m});
  endtask

  // One bus cycle: check what the previous edge produced, then drive the next command.
  task automatic tick(input cmd_e c, input logic [1:0] b, input logic [12:0] a,
                      input logic [1:0] m = 2'b00, input logic [15:0] wd = 16'h0,
                      input logic [2:0] e = 3'd0, input logic ck = 1'b1);
    int          idx;
    logic [15:0] w;
    rd_exp_t     r;
    @(negedge clk);
    monitor();
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b; addr = a; dqm = m; cke = ck; tb_dq = wd;
    tb_drive = (c == CMD_WRITE);
    pend_err = ck ? e : 3'd0;
    idx = int'({b, row_m[b], a[8:0]});
    if (!ck) begin
      for (int i = 0; i < exp_q.size(); i++) exp_q[i].due = exp_q[i].due + 1;
      if (popped_v) begin
        popped.due = edge_cnt + 1;
        exp_q.push_front(popped);
      end
    end else if (e == 3'd0) begin
      case (c)
        CMD_ACT: row_m[b] = a[2:0];
        CMD_WRITE: begin
          w = mem_m.exists(idx) ? mem_m[idx] : 16'h0;
          for (int l = 0; l < 2; l++) if (!m[l]) w[l*8 +: 8] = wd[l*8 +: 8];
          mem_m[idx] = w;
        end
        CMD_READ: begin
          r.due = edge_cnt + cl_m; r.data = mem_m[idx]; r.oe = ~m;
          exp_q.push_back(r);
        end
        CMD_LMR: cl_m = int'(a[6:4]);
        default: ;
      endcase
    end else if (c == CMD_ACT) begin
      row_m[b] = a[2:0];
    end
  endtask

  task automatic nop(input int n = 1);
    repeat (n) tick(CMD_NOP, 2'd0, 13'h0);
  endtask

  task automatic init_seq(input logic [12:0] mode);
    tick(CMD_PRE, 2'd0, 13'h400);
    tick(CMD_REF, 2'd0, 13'h0);
    tick(CMD_REF, 2'd0, 13'h0);
    tick(CMD_LMR, 2'd0, mode);
    nop();
    check("init_done", {31'd0, init_done}, 32'd1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    popped_v = 1'b0;
    pend_err = 3'd0;
    code_m   = 3'd0;
    cl_m     = 3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cke = 1'b1; tb_drive = 1'b0; tb_dq = 16'h0;
    addr = 13'h0; ba = 2'd0; dqm = 2'b00;
    {cs_n, ras_n, cas_n, we_n} = CMD_NOP;
    for (int b = 0; b < 4; b++) row_m[b] = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_err_code",  {29'd0, err_code}, 32'd0);
    check("rst_oe",        {30'd0, dut.dq_lane_oe}, 32'd0);
    rst_n = 1'b1;

    // Command before init, then init with CL=2
    tick(CMD_READ, 2'd0, 13'h0, 2'b00, 16'h0, ERR_NOT_INIT);
    nop();
    check("pre_init_done", {31'd0, init_done}, 32'd0);
    init_seq(13'h020);

    // Write/read, byte masks
    tick(CMD_ACT,   2'd1, 13'd5);
    tick(CMD_WRITE, 2'd1, 13'h010, 2'b00, 16'hBEEF);
    tick(CMD_READ,  2'd1, 13'h010);
    nop(3);
    tick(CMD_WRITE, 2'd1, 13'h010, 2'b01, 16'h1234);
    tick(CMD_READ,  2'd1, 13'h010);
    tick(CMD_READ,  2'd1, 13'h010, 2'b10);
    nop(3);

    // Back-to-back reads, then with a cke stall in the middle
    for (int i = 0; i < 4; i++) tick(CMD_WRITE, 2'd1, 13'(i), 2'b00, 16'hA000 + 16'(i));
    for (int i = 0; i < 4; i++) tick(CMD_READ, 2'd1, 13'(i));
    nop(3);
    tick(CMD_READ, 2'd1, 13'd0);
    tick(CMD_READ, 2'd1, 13'd1);
    tick(CMD_NOP,  2'd0, 13'h0, 2'b00, 16'h0, 3'd0, 1'b0);
    tick(CMD_READ, 2'd1, 13'd2);
    tick(CMD_READ, 2'd1, 13'd3);
    nop(4);

    // READ immediately followed by PRE of the same bank
    tick(CMD_READ, 2'd1, 13'h010);
    tick(CMD_PRE,  2'd1, 13'h000);
    nop(3);

    // Reprogram to CL=3
    tick(CMD_LMR,  2'd0, 13'h030);
    tick(CMD_ACT,  2'd1, 13'd5);
    tick(CMD_READ, 2'd1, 13'h010);
    nop(4);

    // Protocol violations
    tick(CMD_ACT,  2'd1, 13'd5,   2'b00, 16'h0, ERR_BANK_OPEN);
    tick(CMD_READ, 2'd2, 13'h010, 2'b00, 16'h0, ERR_BANK_CLOSED);
    tick(CMD_REF,  2'd0, 13'h0,   2'b00, 16'h0, ERR_REF_OPEN);
    tick(CMD_PRE,  2'd0, 13'h400);
    tick(CMD_LMR,  2'd0, 13'h010, 2'b00, 16'h0, ERR_BAD_MODE);
    tick(CMD_LMR,  2'd0, 13'h031, 2'b00, 16'h0, ERR_BAD_MODE);
    nop();

    // Auto-precharge read at unchanged CL=3, then the bank must be closed
    tick(CMD_ACT,  2'd1, 13'd5);
    tick(CMD_READ, 2'd1, 13'h400);
    tick(CMD_READ, 2'd1, 13'h000, 2'b00, 16'h0, ERR_BANK_CLOSED);
    nop(4);

    // Write while the responder drives dq
    tick(CMD_ACT,   2'd1, 13'd5);
    tick(CMD_READ,  2'd1, 13'd1);
    nop(2);
    tick(CMD_WRITE, 2'd1, 13'h020, 2'b00, 16'h5555, ERR_CONTENTION);
    nop(2);

    // Reset while a read is on the bus
    tick(CMD_READ, 2'd1, 13'd2);
    nop(2);
    @(posedge clk);
    #2;
    check("pend_oe", {30'd0, dut.dq_lane_oe}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_async_oe",   {30'd0, dut.dq_lane_oe}, 32'd0);
    check("rst_async_init", {31'd0, init_done}, 32'd0);
    model_reset();
    {cs_n, ras_n, cas_n, we_n} = CMD_NOP;
    tb_drive = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Storage survives reset
    init_seq(13'h020);
    tick(CMD_ACT,  2'd1, 13'd5);
    tick(CMD_READ, 2'd1, 13'h010);
    tick(CMD_READ, 2'd1, 13'd3);
    nop(4);
    check("drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
